// File: rtl/cp0_ctrl_n_pkg.sv
// CP0 shared definitions: register numbers, exception codes,
// SR/Cause bit positions and an alignment helper.
package cp0_ctrl_n_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int CAUSE_TI = 30;
  localparam int CAUSE_BD = 31;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: free-running Count, Compare match
// raises a sticky pending flag cleared by a Compare write.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wd,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pending
);

  logic hit;

  assign hit = (count == compare) && (compare != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      compare <= '0;
      pending <= 1'b0;
    end else begin
      count <= wr_count ? wd : count + 32'd1;
      if (wr_compare) begin
        compare <= wd;
        pending <= 1'b0;
      end else if (hit) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_ctrl_n.sv
// Coprocessor 0 for the M stage: SR/Cause/EPC/PRId, interrupt
// and exception entry, eret EPC supply with mtc0 bypass.
module cp0_ctrl_n
  import cp0_ctrl_n_pkg::*;
#(
  parameter int          NUM_HW_INT   = 6,
  parameter int          TIMER_EN     = 1,
  parameter int          TIMER_IP_BIT = 7,
  parameter logic [31:0] PRID         = 32'h0C0FFEE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            A,
  input  logic [31:0]           WD,
  input  logic                  WE,
  output logic [31:0]           RD,
  input  logic [4:0]            exc_code,
  input  logic [NUM_HW_INT-1:0] HW_int,
  input  logic [31:0]           PC,
  input  logic                  BD,
  input  logic                  EXL_clr,
  output logic [31:0]           EPC_RD,
  output logic                  int_exc_req,
  output logic                  exl,
  output logic                  timer_irq
);

  logic [7:0]  im;
  logic        ie;
  logic        exl_q;
  logic        bd_q;
  logic [7:0]  ip;
  logic [7:0]  ip_next;
  logic [4:0]  exc_q;
  logic [31:0] epc_q;
  logic [31:0] count;
  logic [31:0] compare;
  logic        pending;
  logic        int_req;
  logic        exc_req;
  logic        wr;
  logic        wr_count;
  logic        wr_compare;
  logic [31:0] sr_rd;
  logic [31:0] cause_rd;

  assign wr         = WE & ~int_exc_req;
  assign wr_count   = wr & (A == CP0_COUNT);
  assign wr_compare = wr & (A == CP0_COMPARE);

  generate
    if (TIMER_EN != 0) begin : g_timer
      cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .wr_count   (wr_count),
        .wr_compare (wr_compare),
        .wd         (WD),
        .count      (count),
        .compare    (compare),
        .pending    (pending)
      );
    end else begin : g_no_timer
      logic unused_tmr;
      assign unused_tmr = wr_count ^ wr_compare;
      assign count      = '0;
      assign compare    = '0;
      assign pending    = 1'b0;
    end
  endgenerate

  always_comb begin
    ip_next = '0;
    ip_next[NUM_HW_INT-1:0] = HW_int;
    if (TIMER_EN != 0) ip_next[TIMER_IP_BIT] = pending;
  end

  assign int_req     = ie & ~exl_q & |(ip_next & im);
  assign exc_req     = (exc_code != '0) & ~exl_q;
  assign int_exc_req = int_req | exc_req;

  always_ff @(posedge clk) begin
    if (!reset) begin
      im    <= '0;
      ie    <= 1'b0;
      exl_q <= 1'b0;
      bd_q  <= 1'b0;
      ip    <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      ip <= ip_next;
      if (int_exc_req) begin
        exl_q <= 1'b1;
        bd_q  <= BD;
        epc_q <= word_align(BD ? PC - 32'd4 : PC);
        exc_q <= int_req ? EXC_INT : exc_code;
      end else begin
        if (EXL_clr) exl_q <= 1'b0;
        // an mtc0 SR in the eret cycle overrides the clear
        if (wr && A == CP0_SR) begin
          im    <= WD[15:8];
          exl_q <= WD[SR_EXL];
          ie    <= WD[SR_IE];
        end
        if (wr && A == CP0_EPC) epc_q <= word_align(WD);
      end
    end
  end

  always_comb begin
    sr_rd           = '0;
    sr_rd[15:8]     = im;
    sr_rd[SR_EXL]   = exl_q;
    sr_rd[SR_IE]    = ie;
    cause_rd           = '0;
    cause_rd[CAUSE_BD] = bd_q;
    cause_rd[CAUSE_TI] = pending;
    cause_rd[15:8]     = ip;
    cause_rd[6:2]      = exc_q;
  end

  always_comb begin
    RD = '0;
    case (A)
      CP0_COUNT:   RD = count;
      CP0_COMPARE: RD = compare;
      CP0_SR:      RD = sr_rd;
      CP0_CAUSE:   RD = cause_rd;
      CP0_EPC:     RD = epc_q;
      CP0_PRID:    RD = PRID;
      default:     RD = '0;
    endcase
  end

  assign EPC_RD    = (WE && A == CP0_EPC) ? word_align(WD) : epc_q;
  assign exl       = exl_q;
  assign timer_irq = pending;

endmodule
